hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Pipeline stall/flush controller for the 5-stage RISC-V core; sits beside the ID-stage Control unit and drives its NoOP_i input.
- Detects load-use hazards, squashes IF/ID on taken branches resolved in ID, and freezes the whole pipeline while a multi-cycle data memory access is outstanding.
- Keeps saturating performance counters and a sticky memory-timeout error flag.

Parameters:
- CNT_W, 16, width of the stall and flush counters.
- WAIT_MAX, 255, number of MEM_WAIT cycles after which err_o is set (must be >= 1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous active-low reset.
- start_i  in  1  level; the core runs while high.
- ID_rs1_i  in  5  rs1 of the instruction in ID.
- ID_rs2_i  in  5  rs2 of the instruction in ID.
- ID_uses_rs2_i  in  1  instruction in ID reads rs2 (R-type, sw, beq).
- EX_MemRead_i  in  1  instruction in EX is a load.
- EX_rd_i  in  5  rd of the instruction in EX.
- ID_branch_taken_i  in  1  beq in ID with equal operands.
- MEM_req_i  in  1  MEM stage issues a data-memory read or write.
- mem_ack_i  in  1  data memory completes the access this cycle.
- PCWrite_o  out  1  PC update enable.
- IFIDWrite_o  out  1  IF/ID register write enable.
- NoOP_o  out  1  to Control NoOP_i; bubbles ID-stage control signals.
- Flush_o  out  1  clears IF/ID to zero, which the Control unit decodes as opcode 0.
- stall_all_o  out  1  freezes the ID/EX, EX/MEM and MEM/WB registers and the PC.
- stall_cnt_o  out  CNT_W  count of cycles with a load-use stall or stall_all_o.
- flush_cnt_o  out  CNT_W  count of Flush_o cycles.
- err_o  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (rst_i=0 at an edge): state=IDLE; wait_cnt=0; both counters=0; err_o=0.
- Combinational outputs take their IDLE values while in reset.
- FSM states: IDLE, RUN, MEM_WAIT.
  - IDLE -> RUN when start_i=1.
  - RUN -> MEM_WAIT when MEM_req_i=1 and mem_ack_i=0.
  - MEM_WAIT -> RUN when mem_ack_i=1.
  - RUN or MEM_WAIT -> IDLE when start_i=0; this takes effect even mid-wait and clears wait_cnt.
- IDLE outputs: PCWrite_o=0, IFIDWrite_o=0, NoOP_o=1, Flush_o=0, stall_all_o=1.
- memstall = (RUN and MEM_req_i and !mem_ack_i) or (MEM_WAIT and !mem_ack_i). Purely combinational, so the first miss cycle stalls with no delay.
- lu = EX_MemRead_i and EX_rd_i!=0 and (EX_rd_i==ID_rs1_i or (ID_uses_rs2_i and EX_rd_i==ID_rs2_i)).
- Priority in RUN/MEM_WAIT: memstall > lu > branch.
  - If memstall: stall_all_o=1, PCWrite_o=0, IFIDWrite_o=0, NoOP_o=0, Flush_o=0. lu and branch are ignored because the pipeline is frozen.
  - Else if lu: PCWrite_o=0, IFIDWrite_o=0, NoOP_o=1, Flush_o=0. Any taken branch re-resolves next cycle.
  - Else if ID_branch_taken_i: Flush_o=1, PCWrite_o=1, IFIDWrite_o=1, NoOP_o=0.
  - Else: PCWrite_o=1, IFIDWrite_o=1, all other outputs 0.
- The ack cycle in MEM_WAIT has stall_all_o=0 and the pipeline advances. This is a zero-latency release.
- wait_cnt:
  - Increments each MEM_WAIT cycle with mem_ack_i=0 and saturates at WAIT_MAX.
  - Clears on ack or on leaving MEM_WAIT.
  - When it reaches WAIT_MAX, err_o is set to 1 on that edge. Only reset clears err_o; the FSM keeps waiting.
- stall_cnt_o increments on each cycle in RUN/MEM_WAIT with memstall or lu.
- flush_cnt_o increments on each cycle with Flush_o=1.
- Both counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum {IDLE, RUN, MEM_WAIT};
  - opcode constants (OP_LW=7'b0000011, OP_SW=7'b0100011, OP_BEQ=7'b1100011, OP_ITYPE=7'b0010011), shared with the Control unit.
- One sub-module, sat_counter (parameter W, inputs inc and clr, output q). It is instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Reset plus start sequence: rst_i=0 for 2 cycles, then start_i=1 → after reset, IDLE outputs (stall_all_o=1, NoOP_o=1); one cycle after start, PCWrite_o=1 and stall_all_o=0; counters and err_o are 0.
- Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs1_i=5 → PCWrite_o=0, IFIDWrite_o=0, NoOP_o=1 for that cycle and stall_cnt_o=1. Repeat with EX_rd_i=0 → no stall.
- Taken branch alone → Flush_o=1, flush_cnt_o=1. Branch plus lu in the same cycle → Flush_o=0, NoOP_o=1.
- Memory miss: MEM_req_i=1 with mem_ack_i low for 3 cycles, then high → stall_all_o=1 for exactly 3 cycles, 0 in the ack cycle; stall_cnt_o=3; state returns to RUN.
- Timeout: WAIT_MAX=4, with mem_ack_i low for 10 cycles → err_o rises after the 4th MEM_WAIT cycle and stays 1 after the ack; only rst_i=0 clears it.
- start_i dropped mid-MEM_WAIT → IDLE next cycle and wait_cnt=0. Drive stall_cnt to all-ones → counter holds its value and does not wrap.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared between the hazard sequencer and the
// ID-stage Control unit of the 5-stage RISC-V core.
//   state_t   - sequencer FSM states
//   OP_*      - opcode constants decoded by Control
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
//   clk - rising-edge clock
//   clr - synchronous clear (wins over inc)
//   inc - count enable
//   q   - current count
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (inc && (q != '1))
         q <= q + W'(1);
   end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush controller for the 5-stage core.
//   clk_i, rst_i            - clock, synchronous active-low reset
//   start_i                 - core runs while high
//   ID_rs1_i/ID_rs2_i/ID_uses_rs2_i - source regs of the ID instruction
//   EX_MemRead_i/EX_rd_i    - load in EX and its destination
//   ID_branch_taken_i       - beq in ID resolved taken
//   MEM_req_i/mem_ack_i     - data-memory handshake of the MEM stage
//   PCWrite_o/IFIDWrite_o/NoOP_o/Flush_o/stall_all_o - pipeline controls
//   stall_cnt_o/flush_cnt_o - saturating performance counters
//   err_o                   - sticky memory-timeout flag
module hazard_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int WAIT_MAX = 255
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       ID_rs1_i,
   input  logic [4:0]       ID_rs2_i,
   input  logic             ID_uses_rs2_i,
   input  logic             EX_MemRead_i,
   input  logic [4:0]       EX_rd_i,
   input  logic             ID_branch_taken_i,
   input  logic             MEM_req_i,
   input  logic             mem_ack_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             NoOP_o,
   output logic             Flush_o,
   output logic             stall_all_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   localparam int                WAIT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_TOP  = WAIT_W'(WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              active;
   logic              memstall;
   logic              lu;
   logic              stall_inc;

   // Reset forces the IDLE output pattern even before the state register
   // has been cleared by an edge.
   assign active = rst_i && (state != IDLE);

   // Combinational so the very first miss cycle in RUN already freezes
   // the pipeline, and the ack cycle releases it with no extra latency.
   assign memstall = active &&
                     (((state == RUN) && MEM_req_i && !mem_ack_i) ||
                      ((state == MEM_WAIT) && !mem_ack_i));

   // x0 is hardwired to zero, so a load to x0 never creates a hazard.
   assign lu = EX_MemRead_i && (EX_rd_i != 5'd0) &&
               ((EX_rd_i == ID_rs1_i) ||
                (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));

   assign stall_inc = active && (memstall || lu);

   always_comb begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOP_o      = 1'b1;
      Flush_o     = 1'b0;
      stall_all_o = 1'b1;
      if (active) begin
         NoOP_o      = 1'b0;
         stall_all_o = 1'b0;
         if (memstall) begin
            // Frozen pipeline: hazards are re-evaluated after release.
            stall_all_o = 1'b1;
         end else if (lu) begin
            // Hold PC and IF/ID; a taken branch re-resolves next cycle.
            NoOP_o = 1'b1;
         end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
            Flush_o     = ID_branch_taken_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state    <= IDLE;
         wait_cnt <= '0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i)
                  state <= RUN;
            end
            RUN: begin
               if (!start_i)
                  state <= IDLE;
               else if (MEM_req_i && !mem_ack_i)
                  state <= MEM_WAIT;
            end
            MEM_WAIT: begin
               if (!start_i) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (mem_ack_i) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else begin
                  if (wait_cnt != WAIT_TOP)
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  // Flag on the edge the count reaches WAIT_MAX; keep waiting.
                  if (wait_cnt >= WAIT_LAST)
                     err_o <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk_i),
      .clr (!rst_i),
      .inc (stall_inc),
      .q   (stall_cnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk_i),
      .clr (!rst_i),
      .inc (Flush_o),
      .q   (flush_cnt_o)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: directed self-checking bench for hazard_sequencer.
// Uses CNT_W=4 so counter saturation is reachable, WAIT_MAX=4 for timeout.
module tb_hazard_sequencer;

   localparam int CNT_W    = 4;
   localparam int WAIT_MAX = 4;

   // {PCWrite, IFIDWrite, NoOP, Flush, stall_all}
   localparam logic [4:0] O_IDLE = 5'b00101;
   localparam logic [4:0] O_RUN  = 5'b11000;
   localparam logic [4:0] O_LU   = 5'b00100;
   localparam logic [4:0] O_BR   = 5'b11010;
   localparam logic [4:0] O_MEM  = 5'b00001;

   logic             clk = 1'b0;
   logic             rst, start, uses_rs2, ex_memread, br, mem_req, mem_ack;
   logic [4:0]       rs1, rs2, ex_rd;
   logic             pcw, ifidw, noop, flush, stall_all, err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [4:0]       outs;

   int total = 0;
   int pass  = 0;

   assign outs = {pcw, ifidw, noop, flush, stall_all};

   always #5 clk = ~clk;

   hazard_sequencer #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .start_i           (start),
      .ID_rs1_i          (rs1),
      .ID_rs2_i          (rs2),
      .ID_uses_rs2_i     (uses_rs2),
      .EX_MemRead_i      (ex_memread),
      .EX_rd_i           (ex_rd),
      .ID_branch_taken_i (br),
      .MEM_req_i         (mem_req),
      .mem_ack_i         (mem_ack),
      .PCWrite_o         (pcw),
      .IFIDWrite_o       (ifidw),
      .NoOP_o            (noop),
      .Flush_o           (flush),
      .stall_all_o       (stall_all),
      .stall_cnt_o       (stall_cnt),
      .flush_cnt_o       (flush_cnt),
      .err_o             (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      rs1 = 5'd0; rs2 = 5'd0; uses_rs2 = 1'b0; ex_memread = 1'b0;
      ex_rd = 5'd0; br = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
   endtask

   // Reset for two edges, then raise start; returns with the FSM in RUN.
   task automatic do_start();
      clear_in();
      rst = 1'b0; start = 1'b0;
      tick(); tick();
      rst = 1'b1; start = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b0; start = 1'b1;
      #1;
      total++; if (outs !== O_IDLE) $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); else pass++;
      tick(); tick();
      total++; if ({stall_cnt, flush_cnt, err} !== '0) $display("FAIL reset_regs got=%h/%h/%b exp=0/0/0", stall_cnt, flush_cnt, err); else pass++;
      rst = 1'b1; start = 1'b0;
      #1;
      total++; if (outs !== O_IDLE) $display("FAIL idle_outs got=%b exp=%b", outs, O_IDLE); else pass++;
      tick();
      start = 1'b1;
      #1;
      total++; if (outs !== O_IDLE) $display("FAIL idle_start_cycle got=%b exp=%b", outs, O_IDLE); else pass++;
      tick();
      total++; if (outs !== O_RUN) $display("FAIL run_after_start got=%b exp=%b", outs, O_RUN); else pass++;
      total++; if ({stall_cnt, flush_cnt, err} !== '0) $display("FAIL run_regs got=%h/%h/%b exp=0/0/0", stall_cnt, flush_cnt, err); else pass++;
   endtask

   task automatic test_load_use();
      do_start();
      ex_memread = 1'b1; ex_rd = 5'd5; rs1 = 5'd5;
      #1;
      total++; if (outs !== O_LU) $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU); else pass++;
      tick();
      total++; if (stall_cnt !== 4'd1) $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); else pass++;
      ex_rd = 5'd0; rs1 = 5'd0;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL lu_x0 got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      ex_rd = 5'd7; rs1 = 5'd1; rs2 = 5'd7; uses_rs2 = 1'b0;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL lu_rs2_unused got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      uses_rs2 = 1'b1;
      #1;
      total++; if (outs !== O_LU) $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU); else pass++;
      tick();
      total++; if (stall_cnt !== 4'd2) $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt); else pass++;
      ex_memread = 1'b0;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL lu_not_load got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
   endtask

   task automatic test_branch();
      do_start();
      br = 1'b1;
      #1;
      total++; if (outs !== O_BR) $display("FAIL br_flush got=%b exp=%b", outs, O_BR); else pass++;
      tick();
      total++; if (flush_cnt !== 4'd1) $display("FAIL br_cnt got=%0d exp=1", flush_cnt); else pass++;
      ex_memread = 1'b1; ex_rd = 5'd9; rs1 = 5'd9;
      #1;
      total++; if (outs !== O_LU) $display("FAIL br_vs_lu got=%b exp=%b", outs, O_LU); else pass++;
      tick();
      total++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd1}) $display("FAIL br_lu_cnts got=%0d/%0d exp=1/1", flush_cnt, stall_cnt); else pass++;
   endtask

   task automatic test_mem_miss();
      do_start();
      mem_req = 1'b1; mem_ack = 1'b0;
      #1;
      total++; if (outs !== O_MEM) $display("FAIL miss_first got=%b exp=%b", outs, O_MEM); else pass++;
      tick();
      // load-use and branch present while frozen: still a plain memory stall
      ex_memread = 1'b1; ex_rd = 5'd4; rs1 = 5'd4; br = 1'b1;
      #1;
      total++; if (outs !== O_MEM) $display("FAIL miss_wait1 got=%b exp=%b", outs, O_MEM); else pass++;
      tick();
      clear_in(); mem_req = 1'b1;
      #1;
      total++; if (outs !== O_MEM) $display("FAIL miss_wait2 got=%b exp=%b", outs, O_MEM); else pass++;
      tick();
      mem_ack = 1'b1;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL miss_ack got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      total++; if ({stall_cnt, flush_cnt} !== {4'd3, 4'd0}) $display("FAIL miss_cnts got=%0d/%0d exp=3/0", stall_cnt, flush_cnt); else pass++;
      mem_req = 1'b1; mem_ack = 1'b1;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL hit_run got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      mem_req = 1'b0; mem_ack = 1'b0;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL hit_stays_run got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      total++; if ({stall_cnt, err} !== {4'd3, 1'b0}) $display("FAIL hit_regs got=%0d/%b exp=3/0", stall_cnt, err); else pass++;
   endtask

   task automatic test_timeout();
      do_start();
      mem_req = 1'b1; mem_ack = 1'b0;
      tick();
      for (int i = 1; i <= 9; i++) begin
         #1;
         total++; if (outs !== O_MEM) $display("FAIL to_stall[%0d] got=%b exp=%b", i, outs, O_MEM); else pass++;
         tick();
         if (i == 3) begin
            total++; if (err !== 1'b0) $display("FAIL to_err_early got=%b exp=0", err); else pass++;
         end
         if (i == 4) begin
            total++; if (err !== 1'b1) $display("FAIL to_err_set got=%b exp=1", err); else pass++;
         end
      end
      mem_ack = 1'b1;
      #1;
      total++; if (outs !== O_RUN) $display("FAIL to_ack got=%b exp=%b", outs, O_RUN); else pass++;
      tick();
      clear_in();
      tick(); tick();
      total++; if ({err, stall_cnt} !== {1'b1, 4'd10}) $display("FAIL to_sticky got=%b/%0d exp=1/10", err, stall_cnt); else pass++;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      total++; if (err !== 1'b0) $display("FAIL to_err_clear got=%b exp=0", err); else pass++;
   endtask

   task automatic test_start_drop();
      do_start();
      mem_req = 1'b1; mem_ack = 1'b0;
      tick(); tick(); tick();   // RUN miss, then two MEM_WAIT cycles
      start = 1'b0;
      #1;
      total++; if (outs !== O_MEM) $display("FAIL drop_cycle got=%b exp=%b", outs, O_MEM); else pass++;
      tick();
      total++; if (outs !== O_IDLE) $display("FAIL drop_idle got=%b exp=%b", outs, O_IDLE); else pass++;
      start = 1'b1;
      tick();                   // back in RUN, request still missing
      tick();                   // enter MEM_WAIT
      for (int i = 1; i <= 4; i++) begin
         tick();
         if (i == 3) begin
            total++; if (err !== 1'b0) $display("FAIL drop_wait_cleared got=%b exp=0", err); else pass++;
         end
         if (i == 4) begin
            total++; if (err !== 1'b1) $display("FAIL drop_err_set got=%b exp=1", err); else pass++;
         end
      end
   endtask

   task automatic test_saturate();
      do_start();
      ex_memread = 1'b1; ex_rd = 5'd3; rs1 = 5'd3;
      repeat (15) tick();
      total++; if (stall_cnt !== 4'hF) $display("FAIL sat_stall_reach got=%0d exp=15", stall_cnt); else pass++;
      repeat (3) tick();
      total++; if (stall_cnt !== 4'hF) $display("FAIL sat_stall_hold got=%0d exp=15", stall_cnt); else pass++;
      clear_in(); br = 1'b1;
      repeat (18) tick();
      total++; if (flush_cnt !== 4'hF) $display("FAIL sat_flush_hold got=%0d exp=15", flush_cnt); else pass++;
      rst = 1'b0;
      tick();
      total++; if ({stall_cnt, flush_cnt} !== '0) $display("FAIL sat_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); else pass++;
      rst = 1'b1; start = 1'b0; clear_in();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_miss();
      test_timeout();
      test_start_drop();
      test_saturate();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
